// File: rtl/sensor_sampler.sv
// Four-channel windowed averager: accumulates 2^AVG_LOG2 readings per channel, then publishes the averages.
// Optional fault detection (readings of 8'h00 / 8'hFF) is built when SENSOR_FAULT_DETECT_EN is defined.
module sensor_sampler #(
    parameter int AVG_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic       raw_valid,
    output logic       raw_ready,
    input  logic [7:0] raw1,
    input  logic [7:0] raw2,
    input  logic [7:0] raw3,
    input  logic [7:0] raw4,
    output logic [7:0] sensor1,
    output logic [7:0] sensor2,
    output logic [7:0] sensor3,
    output logic [7:0] sensor4,
    output logic       out_valid,
    output logic [3:0] sensor_fault
);

    localparam int AW = 8 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state, state_nxt;
    logic [3:0][7:0]      raw;
    logic [3:0][AW-1:0]   acc, sum;
    logic [3:0][7:0]      avg, result, sensor_q;
    logic [CW-1:0]        cnt;
    logic                 accept, last;

    assign raw    = {raw4, raw3, raw2, raw1};
    assign accept = (state == ACCUM) && raw_valid;
    assign last   = accept && (cnt == LAST_CNT);

    // Averages include the reading accepted this cycle so they can be
    // registered on the final accept and be visible during DONE.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum[i] = acc[i] + AW'(raw[i]);
            avg[i] = 8'(sum[i] >> AVG_LOG2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        raw_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:  if (sample_en) state_nxt = ACCUM;
            ACCUM: begin
                raw_ready = 1'b1;
                if (last)            state_nxt = DONE;
                else if (!sample_en) state_nxt = IDLE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_nxt = sample_en ? ACCUM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sums are only meaningful inside ACCUM; any other state leaves them cleared
    // so the next window (or an aborted one) starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (state != ACCUM) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
    end

`ifdef SENSOR_FAULT_DETECT_EN
    logic [3:0] flags, hit, fault_win;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i]    = (raw[i] == 8'h00) || (raw[i] == 8'hFF);
            result[i] = fault_win[i] ? 8'h00 : avg[i];
        end
    end

    assign fault_win = flags | hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags        <= '0;
            sensor_fault <= '0;
        end else begin
            if (state != ACCUM) flags <= '0;
            else if (accept)    flags <= fault_win;
            if (last) sensor_fault <= fault_win;
        end
    end
`else
    assign result       = avg;
    assign sensor_fault = 4'h0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sensor_q <= '0;
        else if (last) sensor_q <= result;
    end

    assign sensor1 = sensor_q[0];
    assign sensor2 = sensor_q[1];
    assign sensor3 = sensor_q[2];
    assign sensor4 = sensor_q[3];

endmodule
